// File: rtl/flipper_axi_read_arbiter.sv
// flipper_axi_read_arbiter: round-robin share of AXI A read channels (AR/R)
// between NUM_REQ internal fetch masters, one outstanding burst at a time.
// Ports: clk, reset (sync, active-high); req_ar* / req_r* requester side,
// flattened per requester; *_a host AXI AR/R side; grant_id, busy status.
// Option: define FLIPPER_ARB_CP_PRIORITY_EN to give requester 0 (CP FIFO)
// absolute priority, the others rotating among themselves.
module flipper_axi_read_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 49,
   parameter int DATA_W  = 128
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
   input  logic [NUM_REQ*8-1:0]      req_arlen,
   input  logic [NUM_REQ-1:0]        req_arvalid,
   output logic [NUM_REQ-1:0]        req_arready,
   output logic [DATA_W-1:0]         req_rdata,
   output logic [1:0]                req_rresp,
   output logic                      req_rlast,
   output logic [NUM_REQ-1:0]        req_rvalid,
   input  logic [NUM_REQ-1:0]        req_rready,
   output logic [ADDR_W-1:0]         araddr_a,
   output logic [7:0]                arlen_a,
   output logic [2:0]                arsize_a,
   output logic [1:0]                arburst_a,
   output logic                      arvalid_a,
   input  logic                      arready_a,
   input  logic [DATA_W-1:0]         rdata_a,
   input  logic [1:0]                rresp_a,
   input  logic                      rlast_a,
   input  logic                      rvalid_a,
   output logic                      rready_a,
   output logic [2:0]                grant_id,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state, state_nx;
   logic [2:0]        last_grant;
   logic [2:0]        winner;
   logic              found;
   logic              cp_win;
   logic [ADDR_W-1:0] win_addr;
   logic [7:0]        win_len;

   assign arsize_a  = 3'b100;
   assign arburst_a = 2'b01;
   assign req_rdata = rdata_a;
   assign req_rresp = rresp_a;
   assign req_rlast = rlast_a;
   assign busy      = (state != IDLE);

   // Scan starts one past the last winner and wraps, so a requester
   // that stays pending is reached within NUM_REQ grants.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = 3'd0;
      cp_win = 1'b0;
`ifdef FLIPPER_ARB_CP_PRIORITY_EN
      if (req_arvalid[0]) begin
         found  = 1'b1;
         cp_win = 1'b1;
      end
`endif
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req_arvalid[idx]) begin
            found  = 1'b1;
            winner = 3'(idx);
         end
      end
   end

   always_comb begin
      win_addr = '0;
      win_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == 3'(i)) begin
            win_addr = req_araddr[i*ADDR_W +: ADDR_W];
            win_len  = req_arlen[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      req_arready = '0;
      req_rvalid  = '0;
      rready_a    = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_nx = ADDR;
               for (int i = 0; i < NUM_REQ; i++)
                  req_arready[i] = (winner == 3'(i));
            end
         end
         ADDR: begin
            if (arready_a) state_nx = DATA;
         end
         DATA: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (grant_id == 3'(i)) begin
                  req_rvalid[i] = rvalid_a;
                  rready_a      = req_rready[i];
               end
            end
            if (rvalid_a && rready_a && rlast_a) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         arvalid_a  <= 1'b0;
         araddr_a   <= '0;
         arlen_a    <= '0;
         grant_id   <= '0;
         last_grant <= 3'(NUM_REQ - 1);
      end else if (state == IDLE && found) begin
         arvalid_a <= 1'b1;
         araddr_a  <= win_addr;
         arlen_a   <= win_len;
         grant_id  <= winner;
         // A priority win by the CP must not disturb the others' rotation.
         if (!cp_win) last_grant <= winner;
      end else if (state == ADDR && arready_a) begin
         arvalid_a <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flipper_axi_read_arbiter.sv
// tb_flipper_axi_read_arbiter: directed vectors and hand sequences for
// flipper_axi_read_arbiter (NUM_REQ=3); also runs with CP priority defined.
module tb_flipper_axi_read_arbiter;

   localparam int N  = 3;
   localparam int AW = 49;
   localparam int DW = 128;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*AW-1:0] req_araddr;
   logic [N*8-1:0]  req_arlen;
   logic [N-1:0]    req_arvalid;
   logic [N-1:0]    req_arready;
   logic [DW-1:0]   req_rdata;
   logic [1:0]      req_rresp;
   logic            req_rlast;
   logic [N-1:0]    req_rvalid;
   logic [N-1:0]    req_rready;
   logic [AW-1:0]   araddr_a;
   logic [7:0]      arlen_a;
   logic [2:0]      arsize_a;
   logic [1:0]      arburst_a;
   logic            arvalid_a;
   logic            arready_a;
   logic [DW-1:0]   rdata_a;
   logic [1:0]      rresp_a;
   logic            rlast_a;
   logic            rvalid_a;
   logic            rready_a;
   logic [2:0]      grant_id;
   logic            busy;

   flipper_axi_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req_araddr(req_araddr), .req_arlen(req_arlen),
      .req_arvalid(req_arvalid), .req_arready(req_arready),
      .req_rdata(req_rdata), .req_rresp(req_rresp),
      .req_rlast(req_rlast), .req_rvalid(req_rvalid),
      .req_rready(req_rready),
      .araddr_a(araddr_a), .arlen_a(arlen_a),
      .arsize_a(arsize_a), .arburst_a(arburst_a),
      .arvalid_a(arvalid_a), .arready_a(arready_a),
      .rdata_a(rdata_a), .rresp_a(rresp_a),
      .rlast_a(rlast_a), .rvalid_a(rvalid_a),
      .rready_a(rready_a),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  av;
      logic [2:0]  arr;
      logic        arv;
      logic [2:0]  rv;
      logic        rr;
      logic        bsy;
      logic [2:0]  gid;
      logic [48:0] addr;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] beat(input int b);
      return {4{32'hA500_0000 + 32'(b)}};
   endfunction

   task automatic idle_inputs();
      req_arvalid = '0;
      req_rready  = '0;
      req_arlen   = '0;
      arready_a   = 1'b0;
      rvalid_a    = 1'b0;
      rlast_a     = 1'b0;
      rdata_a     = '0;
      rresp_a     = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("rst_arvalid", 128'(arvalid_a), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_grant", 128'(grant_id), 128'd0);
      chk("rst_araddr", 128'(araddr_a), 128'd0);
      chk("rst_arlen", 128'(arlen_a), 128'd0);
      chk("rst_rready", 128'(rready_a), 128'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

`ifdef FLIPPER_ARB_CP_PRIORITY_EN
   task automatic burst(input logic [2:0] exp);
      @(negedge clk);
      #1 chk("pri_arready", 128'(req_arready), 128'(exp));
      @(negedge clk);
      #1 chk("pri_arvalid", 128'(arvalid_a), 128'd1);
      @(negedge clk);
      #1 chk("pri_rvalid", 128'(req_rvalid), 128'(exp));
   endtask
`endif

   vec_t tbl[12];
   int   nb;

   initial begin
      reset      = 1'b1;
      req_araddr = '0;
      idle_inputs();

      tbl[0]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 49'h000};
      tbl[1]  = '{3'b111, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 49'h000};
      tbl[2]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 3'd0, 49'h100};
      tbl[3]  = '{3'b111, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1, 3'd0, 49'h100};
      tbl[4]  = '{3'b111, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 49'h100};
      tbl[5]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 3'd1, 49'h200};
      tbl[6]  = '{3'b111, 3'b000, 1'b0, 3'b010, 1'b1, 1'b1, 3'd1, 49'h200};
      tbl[7]  = '{3'b111, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 49'h200};
      tbl[8]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 3'd2, 49'h300};
      tbl[9]  = '{3'b111, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1, 3'd2, 49'h300};
      tbl[10] = '{3'b111, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 49'h300};
      tbl[11] = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 3'd0, 49'h100};

      do_reset();
      chk("arsize", 128'(arsize_a), 128'd4);
      chk("arburst", 128'(arburst_a), 128'd1);

`ifndef FLIPPER_ARB_CP_PRIORITY_EN
      // Round robin, single-beat bursts, stray rvalid in every IDLE row.
      for (int i = 0; i < N; i++)
         req_araddr[i*AW +: AW] = 49'(49'h100 * (i + 1));
      for (int r = 0; r < 12; r++) begin
         @(negedge clk);
         req_arvalid = tbl[r].av;
         req_rready  = 3'b111;
         arready_a   = 1'b1;
         rvalid_a    = 1'b1;
         rlast_a     = 1'b1;
         rdata_a     = beat(r);
         #1;
         chk($sformatf("v%0d_arready", r), 128'(req_arready), 128'(tbl[r].arr));
         chk($sformatf("v%0d_arvalid", r), 128'(arvalid_a), 128'(tbl[r].arv));
         chk($sformatf("v%0d_rvalid", r), 128'(req_rvalid), 128'(tbl[r].rv));
         chk($sformatf("v%0d_rready", r), 128'(rready_a), 128'(tbl[r].rr));
         chk($sformatf("v%0d_busy", r), 128'(busy), 128'(tbl[r].bsy));
         chk($sformatf("v%0d_grant", r), 128'(grant_id), 128'(tbl[r].gid));
         chk($sformatf("v%0d_araddr", r), 128'(araddr_a), 128'(tbl[r].addr));
      end
`else
      // CP priority: 0 always wins, others rotate, 0 returns at once.
      @(negedge clk);
      req_arvalid = 3'b111;
      req_rready  = 3'b111;
      arready_a   = 1'b1;
      rvalid_a    = 1'b1;
      rlast_a     = 1'b1;
      burst(3'b001);
      burst(3'b001);
      burst(3'b001);
      req_arvalid = 3'b110;
      burst(3'b010);
      burst(3'b100);
      burst(3'b010);
      burst(3'b100);
      req_arvalid = 3'b111;
      burst(3'b001);
`endif

      // Requester 1 alone, host AR stalled 5 cycles, 4 beats.
      do_reset();
      req_araddr[1*AW +: AW] = 49'h1_0000_0040;
      @(negedge clk);
      req_arvalid = 3'b010;
      req_arlen   = 24'h00_03_00;
      #1 chk("s2_arready", 128'(req_arready), 128'(3'b010));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_arvalid = '0;
         #1;
         chk("s2_stall_arvalid", 128'(arvalid_a), 128'd1);
         chk("s2_stall_araddr", 128'(araddr_a), 128'h1_0000_0040);
         chk("s2_stall_arlen", 128'(arlen_a), 128'd3);
         chk("s2_stall_rready", 128'(rready_a), 128'd0);
      end
      @(negedge clk);
      arready_a = 1'b1;
      #1 chk("s2_ar_hs", 128'(arvalid_a), 128'd1);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         arready_a  = 1'b0;
         req_rready = 3'b010;
         rvalid_a   = 1'b1;
         rdata_a    = beat(b);
         rlast_a    = (b == 3);
         #1;
         chk("s2_arvalid_low", 128'(arvalid_a), 128'd0);
         chk("s2_rvalid", 128'(req_rvalid), 128'(3'b010));
         chk("s2_rdata", req_rdata, beat(b));
         chk("s2_busy", 128'(busy), 128'd1);
         chk("s2_grant", 128'(grant_id), 128'd1);
      end
      @(negedge clk);
      rvalid_a = 1'b0;
      rlast_a  = 1'b0;
      #1 chk("s2_busy_end", 128'(busy), 128'd0);

      // Requester 2, req_rready toggling; rdata advances only on accept.
      do_reset();
      @(negedge clk);
      req_arvalid = 3'b100;
      req_arlen   = 24'h03_00_00;
      arready_a   = 1'b1;
      #1 chk("s3_arready", 128'(req_arready), 128'(3'b100));
      @(negedge clk);
      req_arvalid = '0;
      #1 chk("s3_arvalid", 128'(arvalid_a), 128'd1);
      nb = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         arready_a  = 1'b0;
         rvalid_a   = 1'b1;
         req_rready = (c % 2 == 0) ? 3'b100 : 3'b000;
         rdata_a    = beat(16 + nb);
         rlast_a    = (nb == 3);
         #1;
         chk("s3_rready", 128'(rready_a), 128'((c % 2) == 0));
         chk("s3_rvalid", 128'(req_rvalid), 128'(3'b100));
         chk("s3_busy", 128'(busy), 128'd1);
         if (c % 2 == 0) begin
            chk("s3_rdata", req_rdata, beat(16 + nb));
            nb++;
         end
      end
      @(negedge clk);
      req_rready = 3'b100;
      rlast_a    = 1'b0;
      #1;
      chk("s3_busy_end", 128'(busy), 128'd0);
      chk("s3_stray_rvalid", 128'(req_rvalid), 128'd0);
      chk("s3_stray_rready", 128'(rready_a), 128'd0);

      // Reset after beat 2 of an 8-beat burst.
      do_reset();
      @(negedge clk);
      req_arvalid = 3'b010;
      req_arlen   = 24'h00_07_00;
      arready_a   = 1'b1;
      #1 chk("s4_arready", 128'(req_arready), 128'(3'b010));
      @(negedge clk);
      req_arvalid = '0;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         arready_a  = 1'b0;
         rvalid_a   = 1'b1;
         req_rready = 3'b010;
         #1 chk("s4_rvalid", 128'(req_rvalid), 128'(3'b010));
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      req_arvalid = 3'b111;
      #1;
      chk("s4_busy", 128'(busy), 128'd0);
      chk("s4_arvalid", 128'(arvalid_a), 128'd0);
      chk("s4_rready", 128'(rready_a), 128'd0);
      chk("s4_rvalid", 128'(req_rvalid), 128'd0);
      chk("s4_next_grant", 128'(req_arready), 128'(3'b001));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
